// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Groups the two master request channels and the shared device bus.
//   mN_req/mN_addr/mN_wdata/mN_we : master N request (held until ack or err)
//   mN_rdata/mN_ack/mN_err        : completion info returned to master N
//   en/addr/wdata/we              : shared bus toward decoders and devices
//   rdata/rdy                     : device response
// Handshake: a master raises mN_req with stable payload and keeps it until it
// sees a one-cycle mN_ack (done, mN_rdata valid) or mN_err (timed out). The
// device finishes a cycle by raising rdy while en is high; rdy is ignored
// otherwise.
// modport slave  : the arbiter's view
// modport master : the view of the environment (masters plus device)
// -----------------------------------------------------------------------------
interface bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_we;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_we;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        m1_err;

  logic        en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        rdy;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_we,
    input  rdata, rdy,
    output m0_rdata, m0_ack, m0_err,
    output m1_rdata, m1_ack, m1_err,
    output en, addr, wdata, we
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_we,
    output rdata, rdy,
    input  m0_rdata, m0_ack, m0_err,
    input  m1_rdata, m1_ack, m1_err,
    input  en, addr, wdata, we
  );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master round-robin arbiter for a single shared bus with a transfer
// timeout. One transfer is in flight at a time; every output is registered.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : bus_arbiter_if.slave (master channels + device bus)
//   o_state : debug view of the FSM state (0 IDLE, 1 BUSY)
// Parameter TIMEOUT (2..255): BUSY cycles without rdy before the transfer is
// aborted with an err strobe to its owner.
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  bus_arbiter_if.slave       bus,
  output logic               o_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_en,     w_en_nxt;
  logic [31:0] r_addr,   w_addr_nxt;
  logic [31:0] r_wdata,  w_wdata_nxt;
  logic        r_we,     w_we_nxt;
  logic [7:0]  r_cnt,    w_cnt_nxt;
  logic        r_owner,  w_owner_nxt;
  logic        r_last,   w_last_nxt;
  logic        r_ack0,   w_ack0_nxt;
  logic        r_ack1,   w_ack1_nxt;
  logic        r_err0,   w_err0_nxt;
  logic        r_err1,   w_err1_nxt;
  logic [31:0] r_rdata0, w_rdata0_nxt;
  logic [31:0] r_rdata1, w_rdata1_nxt;

  // A master that is being strobed this cycle is still holding req while it
  // observes the strobe, so it must not be re-granted on that same edge.
  logic w_elig0, w_elig1, w_grant_vld, w_grant_sel, w_timeout;

  always_comb begin
    w_elig0     = bus.m0_req & ~r_ack0 & ~r_err0;
    w_elig1     = bus.m1_req & ~r_ack1 & ~r_err1;
    w_grant_vld = w_elig0 | w_elig1;
    // On a tie the master not granted last wins; otherwise the only one.
    w_grant_sel = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
    // rdy has priority over the timeout in the same cycle.
    w_timeout   = ~bus.rdy & (r_cnt == CNT_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_vld)           w_state_nxt = ST_BUSY;
      ST_BUSY: if (bus.rdy || w_timeout)  w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and datapath
  always_comb begin
    w_en_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = r_we;
    w_cnt_nxt    = r_cnt;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_ack0_nxt   = 1'b0;
    w_ack1_nxt   = 1'b0;
    w_err0_nxt   = 1'b0;
    w_err1_nxt   = 1'b0;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_en_nxt    = 1'b1;
          w_owner_nxt = w_grant_sel;
          w_last_nxt  = w_grant_sel;
          w_cnt_nxt   = 8'd0;
          w_addr_nxt  = w_grant_sel ? bus.m1_addr  : bus.m0_addr;
          w_wdata_nxt = w_grant_sel ? bus.m1_wdata : bus.m0_wdata;
          w_we_nxt    = w_grant_sel ? bus.m1_we    : bus.m0_we;
        end
      end
      ST_BUSY: begin
        if (bus.rdy) begin
          // Reads and writes alike return the device rdata to the owner.
          if (r_owner) begin
            w_ack1_nxt   = 1'b1;
            w_rdata1_nxt = bus.rdata;
          end else begin
            w_ack0_nxt   = 1'b1;
            w_rdata0_nxt = bus.rdata;
          end
        end else if (w_timeout) begin
          if (r_owner) begin
            w_err1_nxt   = 1'b1;
            w_rdata1_nxt = 32'd0;
          end else begin
            w_err0_nxt   = 1'b1;
            w_rdata0_nxt = 32'd0;
          end
        end else begin
          w_en_nxt  = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Output/datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_we     <= 1'b0;
      r_cnt    <= 8'd0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      r_en     <= w_en_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_we     <= w_we_nxt;
      r_cnt    <= w_cnt_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_ack0   <= w_ack0_nxt;
      r_ack1   <= w_ack1_nxt;
      r_err0   <= w_err0_nxt;
      r_err1   <= w_err1_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
    end
  end

  assign bus.en       = r_en;
  assign bus.addr     = r_addr;
  assign bus.wdata    = r_wdata;
  assign bus.we       = r_we;
  assign bus.m0_ack   = r_ack0;
  assign bus.m1_ack   = r_ack1;
  assign bus.m0_err   = r_err0;
  assign bus.m1_err   = r_err1;
  assign bus.m0_rdata = r_rdata0;
  assign bus.m1_rdata = r_rdata1;
  assign o_state      = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter (TIMEOUT=4). Inputs change 1ns after each
// rising edge; registered outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic clk;
  logic rst;
  logic st;

  int n_checks;
  int n_fail;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif.slave),
    .o_state (st)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic req0(input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic w);
    bif.m0_req = r; bif.m0_addr = a; bif.m0_wdata = d; bif.m0_we = w;
  endtask

  task automatic req1(input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic w);
    bif.m1_req = r; bif.m1_addr = a; bif.m1_wdata = d; bif.m1_we = w;
  endtask

  task automatic dev(input logic r, input logic [31:0] d);
    bif.rdy = r; bif.rdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] exp_addr [4];
  logic        exp_m1   [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    req0(1'b0, 32'd0, 32'd0, 1'b0);
    req1(1'b0, 32'd0, 32'd0, 1'b0);
    dev(1'b0, 32'd0);

    // Reset values
    do_reset();
    check_eq("rst_en",     bif.en,       32'd0);
    check_eq("rst_we",     bif.we,       32'd0);
    check_eq("rst_addr",   bif.addr,     32'd0);
    check_eq("rst_wdata",  bif.wdata,    32'd0);
    check_eq("rst_strobe", {bif.m0_ack, bif.m0_err, bif.m1_ack, bif.m1_err}, 32'd0);
    check_eq("rst_rdata0", bif.m0_rdata, 32'd0);
    check_eq("rst_state",  st,           32'd0);

    // rdy while IDLE is ignored
    dev(1'b1, 32'h1234_5678);
    tick();
    check_eq("idle_rdy_en",  bif.en,     32'd0);
    check_eq("idle_rdy_ack", bif.m0_ack, 32'd0);
    dev(1'b0, 32'd0);

    // Single read: rdy on 2nd BUSY cycle
    req0(1'b1, 32'h0000_1004, 32'd0, 1'b0);
    tick();
    check_eq("rd_en1",   bif.en,   32'd1);
    check_eq("rd_addr",  bif.addr, 32'h0000_1004);
    check_eq("rd_we",    bif.we,   32'd0);
    check_eq("rd_state", st,       32'd1);
    tick();
    check_eq("rd_en2",   bif.en,   32'd1);
    dev(1'b1, 32'hDEAD_BEEF);
    tick();
    check_eq("rd_en_off", bif.en,       32'd0);
    check_eq("rd_ack",    bif.m0_ack,   32'd1);
    check_eq("rd_rdata",  bif.m0_rdata, 32'hDEAD_BEEF);
    check_eq("rd_m1",     {bif.m1_ack, bif.m1_err}, 32'd0);
    check_eq("rd_m1rd",   bif.m1_rdata, 32'd0);
    req0(1'b0, 32'd0, 32'd0, 1'b0);
    dev(1'b0, 32'd0);
    tick();
    check_eq("rd_ack_1cyc", bif.m0_ack, 32'd0);

    // Contention after reset: m0, m1, m0, m1
    do_reset();
    exp_addr[0] = 32'h0000_00A0; exp_m1[0] = 1'b0;
    exp_addr[1] = 32'h0000_00B0; exp_m1[1] = 1'b1;
    exp_addr[2] = 32'h0000_00A0; exp_m1[2] = 1'b0;
    exp_addr[3] = 32'h0000_00B0; exp_m1[3] = 1'b1;
    req0(1'b1, 32'h0000_00A0, 32'h1, 1'b1);
    req1(1'b1, 32'h0000_00B0, 32'h2, 1'b1);
    dev(1'b1, 32'h1111_2222);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("rr_en%0d", i),   bif.en,   32'd1);
      check_eq($sformatf("rr_addr%0d", i), bif.addr, exp_addr[i]);
      tick();
      if (i == 3) begin
        req0(1'b0, 32'd0, 32'd0, 1'b0);
        req1(1'b0, 32'd0, 32'd0, 1'b0);
        dev(1'b0, 32'd0);
      end
      check_eq($sformatf("rr_idle%0d", i), bif.en, 32'd0);
      check_eq($sformatf("rr_ack%0d", i), {bif.m0_ack, bif.m1_ack},
               exp_m1[i] ? 32'd1 : 32'd2);
    end
    tick();
    check_eq("rr_end_en", bif.en, 32'd0);

    // Timeout: m1 write, rdy held low
    req1(1'b1, 32'h2000_0000, 32'h5555_AAAA, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("to_en%0d", i), bif.en, 32'd1);
      check_eq($sformatf("to_err_early%0d", i), bif.m1_err, 32'd0);
    end
    check_eq("to_addr",  bif.addr,  32'h2000_0000);
    check_eq("to_wdata", bif.wdata, 32'h5555_AAAA);
    check_eq("to_we",    bif.we,    32'd1);
    tick();
    check_eq("to_en_off", bif.en,       32'd0);
    check_eq("to_err",    bif.m1_err,   32'd1);
    check_eq("to_noack",  bif.m1_ack,   32'd0);
    check_eq("to_rdata",  bif.m1_rdata, 32'd0);
    check_eq("to_m0",     {bif.m0_ack, bif.m0_err}, 32'd0);
    req1(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check_eq("to_err_1cyc", bif.m1_err, 32'd0);

    // Timeout tie: rdy in the 4th BUSY cycle wins
    req0(1'b1, 32'h0000_0300, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("tie_en%0d", i), bif.en, 32'd1);
    end
    dev(1'b1, 32'hCAFE_F00D);
    tick();
    check_eq("tie_ack",   bif.m0_ack,   32'd1);
    check_eq("tie_noerr", bif.m0_err,   32'd0);
    check_eq("tie_rdata", bif.m0_rdata, 32'hCAFE_F00D);
    req0(1'b0, 32'd0, 32'd0, 1'b0);
    dev(1'b0, 32'd0);
    tick();

    // Stability: address change mid-BUSY is not seen on the bus
    req0(1'b1, 32'h0000_0010, 32'h0000_00AA, 1'b1);
    tick();
    check_eq("stb_addr1", bif.addr, 32'h0000_0010);
    req0(1'b1, 32'h0000_0020, 32'h0000_00BB, 1'b0);
    tick();
    check_eq("stb_addr2",  bif.addr,  32'h0000_0010);
    check_eq("stb_wdata2", bif.wdata, 32'h0000_00AA);
    check_eq("stb_we2",    bif.we,    32'd1);
    dev(1'b1, 32'h0000_0077);
    tick();
    check_eq("stb_ack",  bif.m0_ack, 32'd1);
    check_eq("stb_addr3", bif.addr,  32'h0000_0010);
    req0(1'b0, 32'd0, 32'd0, 1'b0);
    dev(1'b0, 32'd0);
    tick();

    // Reset mid-BUSY during an m1 transfer (rdy high as well: rst dominates)
    req1(1'b1, 32'h0000_0040, 32'd0, 1'b0);
    tick();
    check_eq("rmb_en", bif.en, 32'd1);
    rst = 1'b1;
    dev(1'b1, 32'h9999_9999);
    tick();
    rst = 1'b0;
    dev(1'b0, 32'd0);
    check_eq("rmb_en_off", bif.en, 32'd0);
    check_eq("rmb_strobe", {bif.m0_ack, bif.m0_err, bif.m1_ack, bif.m1_err}, 32'd0);
    check_eq("rmb_state",  st, 32'd0);
    req0(1'b1, 32'h0000_0050, 32'd0, 1'b0);
    tick();
    check_eq("rmb_grant_en",   bif.en,   32'd1);
    check_eq("rmb_grant_addr", bif.addr, 32'h0000_0050);
    dev(1'b1, 32'h0000_0001);
    tick();
    check_eq("rmb_ack0", {bif.m0_ack, bif.m1_ack}, 32'd2);
    req0(1'b0, 32'd0, 32'd0, 1'b0);
    req1(1'b0, 32'd0, 32'd0, 1'b0);
    dev(1'b0, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: BUSY cycles without rdy before a transfer is aborted with err; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mN_req  input  1  master N (N = 0,1) transfer request; held high with mN_addr/mN_wdata/mN_we stable until mN_ack or mN_err.
REQ-005 mN_addr  input  32  master N byte address.
REQ-006 mN_wdata  input  32  master N write data.
REQ-007 mN_we  input  1  master N write enable (1 write, 0 read).
REQ-008 mN_rdata  output  32  read data returned to master N; valid while mN_ack is high.
REQ-009 mN_ack  output  1  one-cycle completion strobe to master N.
REQ-010 mN_err  output  1  one-cycle timeout strobe to master N.
REQ-011 en  output  1  bus enable to address decoders and devices.
REQ-012 addr  output  32  bus address.
REQ-013 wdata  output  32  bus write data.
REQ-014 we  output  1  bus write enable.
REQ-015 rdata  input  32  read data from selected device.
REQ-016 rdy  input  1  device completion; sampled only while en is high.

Function
REQ-017 The block SHALL implement a two-state FSM: IDLE (en=0) and BUSY (en=1); all outputs SHALL be registered.
REQ-018 In IDLE, a master SHALL be eligible when mN_req=1 and its mN_ack and mN_err are both 0 in that cycle.
REQ-019 In IDLE with exactly one eligible master, the next edge SHALL grant it: state->BUSY, owner<-N, addr/wdata/we latched from mN_*, timeout counter<-0.
REQ-020 With both eligible, the grant SHALL go to the master not granted last (round-robin); the last-grant pointer SHALL update on every grant.
REQ-021 While BUSY, addr/wdata/we SHALL hold their latched values regardless of mN_* changes.
REQ-022 BUSY with rdy=1: next edge SHALL set owner ack=1, owner rdata<-rdata (reads and writes alike), state->IDLE, en->0.
REQ-023 BUSY with rdy=0: counter SHALL increment; when counter equals TIMEOUT-1 with rdy=0, next edge SHALL set owner err=1, owner rdata<-0, state->IDLE.
REQ-024 rdy=1 in the same cycle as timeout SHALL win: ack, never err.
REQ-025 mN_ack and mN_err SHALL be high for exactly one cycle and never both; the non-owner SHALL see no strobe and unchanged mN_rdata.
REQ-026 Minimum transfer: request seen in IDLE at edge k, en high in cycle k+1; rdy in that cycle gives ack in cycle k+2; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-027 rdy while IDLE SHALL be ignored.
REQ-028 mN_req dropping while BUSY SHALL NOT abort the transfer; it still completes with ack or err.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, en/we=0, addr/wdata=0, mN_ack/mN_err=0, mN_rdata=0, counter=0, last-grant pointer=1 (m0 wins first tie).
REQ-030 Reset during BUSY SHALL abandon the transfer with no ack or err to either master; rst SHALL dominate all other inputs.

Verification
REQ-031 Single read: m0 req addr=0x00001004, we=0; device rdy=1 with rdata=0xDEADBEEF on 2nd BUSY cycle -> en high 2 cycles, addr=0x00001004, m0_ack one cycle with m0_rdata=0xDEADBEEF, m1 silent.
REQ-032 Contention: m0 and m1 request together after reset, rdy immediate -> grant order m0, m1, m0, m1 with exactly one IDLE cycle between transfers.
REQ-033 Timeout: TIMEOUT=4, m1 write addr=0x20000000, rdy held 0 -> en high exactly 4 cycles, then m1_err one cycle, m1_rdata=0, m1_ack never high.
REQ-034 Timeout tie: TIMEOUT=4, rdy=1 in 4th BUSY cycle -> ack, no err.
REQ-035 Stability: m0 changes m0_addr 0x10->0x20 mid-BUSY -> bus addr stays 0x10 until completion.
REQ-036 Reset mid-BUSY: rst pulsed one cycle during m1 transfer -> next cycle en=0, no strobes; re-request granted m0 first on tie.
